// File: rtl/fmap_pkg.sv
// Shared types and constants for the feature-map stream source and its FIFO.
package fmap_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int FIFO_DEPTH = 4;

  function automatic int word_width(input int data_w, input int channels);
    return data_w * channels;
  endfunction

endpackage

// File: rtl/fmap_fifo4.sv
// Four-entry synchronous FIFO with occupancy count; a push and a pop on the same
// edge leave the count unchanged.
module fmap_fifo4
  import fmap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [2:0]       o_count
);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [2:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != 3'd0);
  assign w_push = i_push && ((r_count != 3'(FIFO_DEPTH)) || w_pop);

  // Storage is not reset; the owner masks the head word while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fmap_stream_source.sv
// Streams one stored feature map from a sync-read RAM in raster order with ready/valid
// backpressure. Define FMAP_LAST_EN to add o_Last_Out, flagging the final pixel at the head.
module fmap_stream_source
  import fmap_pkg::*;
#(
  parameter int DATA_WIDHT = 32,
  parameter int CHANNEL    = 8,
  parameter int IMG_WIDTH  = 46,
  parameter int IMG_HEIGHT = 46,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        i_Start,
  output logic                                        o_Mem_Rd_En,
  output logic [ADDR_WIDTH-1:0]                       o_Mem_Addr,
  input  logic [word_width(DATA_WIDHT, CHANNEL)-1:0]  i_Mem_Data,
  output logic [word_width(DATA_WIDHT, CHANNEL)-1:0]  o_Data_Out,
  output logic                                        o_Valid_Out,
  input  logic                                        i_Ready_In,
  output logic                                        o_Busy,
  output logic                                        o_Done
`ifdef FMAP_LAST_EN
  ,
  output logic                                        o_Last_Out
`endif
);

  localparam int WORD_W = word_width(DATA_WIDHT, CHANNEL);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
`ifdef FMAP_LAST_EN
  localparam int ENTRY_W = WORD_W + 1;
`else
  localparam int ENTRY_W = WORD_W;
`endif

  state_t                r_state;
  logic                  r_rd_en;
  logic                  r_rd_pend;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [ADDR_WIDTH-1:0] r_xfer_cnt;

  logic [2:0]            w_count;
  logic [3:0]            w_used;
  logic [ENTRY_W-1:0]    w_push_entry;
  logic [ENTRY_W-1:0]    w_head_entry;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_last_issue;
  logic                  w_final_xfer;
  logic [ADDR_WIDTH-1:0] w_issue_addr;

  assign w_valid = (w_count != 3'd0);
  assign w_pop   = w_valid && i_Ready_In;

  // Credit covers words already queued plus both RAM pipeline stages; the word
  // leaving this edge frees its slot so a steady stream has no bubbles.
  assign w_used       = {1'b0, w_count} + {3'b000, r_rd_pend} + {3'b000, r_rd_en} - {3'b000, w_pop};
  assign w_issue      = ((r_state == IDLE) && i_Start) ||
                        ((r_state == RUN) && (w_used < 4'(FIFO_DEPTH)));
  assign w_issue_addr = (r_state == IDLE) ? '0 : r_next_addr;
  assign w_last_issue = w_issue && (w_issue_addr == LAST_ADDR);
  assign w_final_xfer = w_pop && (r_xfer_cnt == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rd_en     <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= '0;
      r_next_addr <= '0;
      r_xfer_cnt  <= '0;
    end else begin
      r_rd_en   <= w_issue;
      r_rd_pend <= r_rd_en;
      r_done    <= 1'b0;
      if (w_issue) begin
        r_addr      <= w_issue_addr;
        r_next_addr <= w_last_issue ? '0 : w_issue_addr + ADDR_ONE;
      end
      if (w_pop) begin
        r_xfer_cnt <= w_final_xfer ? '0 : r_xfer_cnt + ADDR_ONE;
      end
      case (r_state)
        IDLE: begin
          if (i_Start) begin
            r_busy  <= 1'b1;
            r_state <= w_last_issue ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (w_last_issue) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_final_xfer) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef FMAP_LAST_EN
  logic r_en_last;
  logic r_pend_last;

  // The last-pixel flag follows its read through both RAM stages into the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_last   <= 1'b0;
      r_pend_last <= 1'b0;
    end else begin
      r_en_last   <= w_last_issue;
      r_pend_last <= r_en_last;
    end
  end

  assign w_push_entry = {r_pend_last, i_Mem_Data};
  assign o_Last_Out   = w_valid && w_head_entry[WORD_W];
`else
  assign w_push_entry = i_Mem_Data;
`endif

  fmap_fifo4 #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_rd_pend),
    .i_data (w_push_entry),
    .i_pop  (w_pop),
    .o_data (w_head_entry),
    .o_count(w_count)
  );

  assign o_Mem_Rd_En = r_rd_en;
  assign o_Mem_Addr  = r_addr;
  assign o_Valid_Out = w_valid;
  assign o_Data_Out  = w_valid ? w_head_entry[WORD_W-1:0] : '0;
  assign o_Busy      = r_busy;
  assign o_Done      = r_done;

endmodule
